// File: rtl/seg_counter_display.sv
// Multiplexed N-digit BCD counter driving common-anode seven-segment displays.
// Counts on a prescaled tick (up or down), with load, wrap pulse, leading-zero
// blanking and per-digit decimal points. sel/seg are active low.
module seg_counter_display #(
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned TICK_MAX = 499_999,
  parameter int unsigned SCAN_MAX = 49_999,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg
);

  localparam int unsigned CNT_W = 4 * DIGITS;
  localparam int unsigned PRE_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam int unsigned SCN_W = (SCAN_MAX > 0) ? $clog2(SCAN_MAX + 1) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [SCN_W-1:0]  scan_q, scan_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;

  logic              tick_c;
  logic [CNT_W-1:0]  step_c;
  logic              step_wrap_c;
  logic [CNT_W-1:0]  load_clamp_c;
  logic [3:0]        dig_c, nd_c;
  logic              carry_c;
  logic [DIGITS-1:0] lz_c;
  logic              zacc_c;
  logic [3:0]        cur_dig_c;
  logic              cur_dp_c;
  logic              cur_blank_c;

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-BCD codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign tick_c = en && (presc_q == PRE_W'(TICK_MAX));

  // BCD increment/decrement with ripple carry/borrow; final carry flags a wrap.
  always_comb begin
    step_c  = count_q;
    carry_c = 1'b1;
    dig_c   = 4'd0;
    nd_c    = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig_c = count_q[4*i +: 4];
      nd_c  = dig_c;
      if (carry_c) begin
        if (up_dn) begin
          if (dig_c >= 4'd9) nd_c = 4'd0;
          else begin nd_c = 4'(dig_c + 4'd1); carry_c = 1'b0; end
        end else begin
          if (dig_c == 4'd0) nd_c = 4'd9;
          else begin nd_c = 4'(dig_c - 4'd1); carry_c = 1'b0; end
        end
      end
      step_c[4*i +: 4] = nd_c;
    end
    step_wrap_c = carry_c;
  end

  // Clamp any non-BCD load digit to 9.
  always_comb begin
    load_clamp_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      load_clamp_c[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  // Prescaler and counter next state; load overrides the tick.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      presc_d = '0;
      count_d = load_clamp_c;
    end else if (en) begin
      presc_d = tick_c ? '0 : PRE_W'(presc_q + 1'b1);
      if (tick_c) begin
        count_d = step_c;
        wrap_d  = step_wrap_c;
      end
    end
  end

  // Free-running scan timer and digit index.
  always_comb begin
    scan_d = PRE_W > 0 ? SCN_W'(scan_q + 1'b1) : scan_q;
    idx_d  = idx_q;
    if (scan_q == SCN_W'(SCAN_MAX)) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : IDX_W'(idx_q + 1'b1);
    end
  end

  // Leading-zero map: lz_c[i] set when digit i and every digit above it are 0.
  always_comb begin
    zacc_c = 1'b1;
    lz_c   = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zacc_c  = zacc_c && (count_q[4*i +: 4] == 4'd0);
      lz_c[i] = zacc_c;
    end
  end

  // Select the scanned digit and build the next sel/seg pin values.
  always_comb begin
    cur_dig_c   = 4'd0;
    cur_dp_c    = 1'b0;
    cur_blank_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_dig_c   = count_q[4*i +: 4];
        cur_dp_c    = dp_mask[i];
        cur_blank_c = BLANK_LZ && lz_c[i] && (i != 0);
      end
    end
    sel_d = ~(DIGITS'(1) << idx_q);
    seg_d = {~cur_dp_c, cur_blank_c ? 7'h7F : seg7(cur_dig_c)};
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      sel_q   <= '1;
      seg_q   <= 8'hFF;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign sel       = sel_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_seg_counter_display.sv
// Directed bench for seg_counter_display with DIGITS=4, TICK_MAX=3, SCAN_MAX=1.
module tb_seg_counter_display;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;
  logic [3:0]  dp_mask;
  logic [15:0] count_bcd;
  logic        wrap;
  logic [3:0]  sel;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  seg_counter_display #(
    .DIGITS  (4),
    .TICK_MAX(3),
    .SCAN_MAX(1),
    .BLANK_LZ(1'b1)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .dp_mask  (dp_mask),
    .count_bcd(count_bcd),
    .wrap     (wrap),
    .sel      (sel),
    .seg      (seg)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    load     = 1'b1;
    @(negedge sys_clk);
    load     = 1'b0;
  endtask

  // Wait (bounded) for the first cycle in which digit 0 becomes selected.
  task automatic wait_digit0();
    logic [3:0] prev;
    logic       found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      prev = sel;
      @(negedge sys_clk);
      if (prev != 4'b1110 && sel == 4'b1110) found = 1'b1;
    end
    check("scan_sync_timeout", 32'(found), 32'd1);
  endtask

  logic [3:0] sel_tab [4];
  logic [7:0] seg_tab [4];
  logic [7:0] zero_tab [4];

  initial begin
    sel_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab  = '{8'h92, 8'h40, 8'hA4, 8'hFF};
    zero_tab = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};

    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0;
    load_val = 16'h0000; dp_mask = 4'b0000;
    tick_n(3);
    check("rst_count", 32'(count_bcd), 32'h0);
    check("rst_wrap",  32'(wrap), 32'h0);
    check("rst_sel",   32'(sel), 32'hF);
    check("rst_seg",   32'(seg), 32'hFF);

    // 1: count up from reset, BCD carry into digit 1
    en = 1'b1; up_dn = 1'b1;
    rst_n = 1'b1;
    @(negedge sys_clk);
    check("t1_sel_first", 32'(sel), 32'hE);
    check("t1_cnt_c1", 32'(count_bcd), 32'h0);
    tick_n(2);
    check("t1_cnt_c3", 32'(count_bcd), 32'h0);
    @(negedge sys_clk);
    check("t1_cnt_c4", 32'(count_bcd), 32'h1);
    for (int k = 2; k <= 10; k++) begin
      tick_n(3);
      check("t1_hold", 32'(count_bcd), 32'(((k - 1) / 10) * 16 + (k - 1) % 10));
      check("t1_wrap", 32'(wrap), 32'h0);
      @(negedge sys_clk);
      check("t1_step", 32'(count_bcd), 32'((k / 10) * 16 + k % 10));
    end
    check("t1_final", 32'(count_bcd), 32'h0010);

    // 2: up-count wrap 9999 -> 0000
    do_load(16'h9998);
    check("t2_load", 32'(count_bcd), 32'h9998);
    tick_n(4);
    check("t2_9999", 32'(count_bcd), 32'h9999);
    check("t2_nowrap", 32'(wrap), 32'h0);
    tick_n(3);
    check("t2_hold", 32'(count_bcd), 32'h9999);
    @(negedge sys_clk);
    check("t2_0000", 32'(count_bcd), 32'h0000);
    check("t2_wrap_hi", 32'(wrap), 32'h1);
    @(negedge sys_clk);
    check("t2_wrap_lo", 32'(wrap), 32'h0);

    // 3: down-count wrap 0000 -> 9999
    up_dn = 1'b0;
    do_load(16'h0001);
    check("t3_load", 32'(count_bcd), 32'h0001);
    tick_n(4);
    check("t3_0000", 32'(count_bcd), 32'h0000);
    check("t3_nowrap", 32'(wrap), 32'h0);
    tick_n(4);
    check("t3_9999", 32'(count_bcd), 32'h9999);
    check("t3_wrap_hi", 32'(wrap), 32'h1);
    @(negedge sys_clk);
    check("t3_wrap_lo", 32'(wrap), 32'h0);
    tick_n(3);
    check("t3_9998", 32'(count_bcd), 32'h9998);

    // 4: load coincident with tick (prescaler at terminal), clamped digit
    up_dn = 1'b1;
    tick_n(3);
    do_load(16'h12F4);
    check("t4_clamp", 32'(count_bcd), 32'h1294);
    check("t4_wrap", 32'(wrap), 32'h0);
    tick_n(3);
    check("t4_hold", 32'(count_bcd), 32'h1294);
    @(negedge sys_clk);
    check("t4_step", 32'(count_bcd), 32'h1295);
    en = 1'b0;
    tick_n(21);
    check("t4_frozen", 32'(count_bcd), 32'h1295);
    en = 1'b1;
    tick_n(3);
    check("t4_resume_hold", 32'(count_bcd), 32'h1295);
    @(negedge sys_clk);
    check("t4_resume_step", 32'(count_bcd), 32'h1296);

    // 5: scan pattern with dp and leading-zero blanking
    en = 1'b0;
    dp_mask = 4'b0010;
    do_load(16'h0205);
    wait_digit0();
    for (int d = 0; d < 4; d++) begin
      for (int h = 0; h < 2; h++) begin
        check("t5_sel", 32'(sel), 32'(sel_tab[d]));
        check("t5_seg", 32'(seg), 32'(seg_tab[d]));
        @(negedge sys_clk);
      end
    end
    dp_mask = 4'b0000;
    do_load(16'h0000);
    wait_digit0();
    for (int d = 0; d < 4; d++) begin
      check("t5z_sel", 32'(sel), 32'(sel_tab[d]));
      check("t5z_seg", 32'(seg), 32'(zero_tab[d]));
      tick_n(2);
    end

    // 6: asynchronous reset mid-scan
    do_load(16'h0777);
    tick_n(3);
    check("t6_pre", 32'(count_bcd), 32'h0777);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_sel", 32'(sel), 32'hF);
    check("t6_rst_seg", 32'(seg), 32'hFF);
    check("t6_rst_cnt", 32'(count_bcd), 32'h0);
    check("t6_rst_wrap", 32'(wrap), 32'h0);
    tick_n(2);
    rst_n = 1'b1;
    @(negedge sys_clk);
    check("t6_sel0", 32'(sel), 32'hE);
    check("t6_seg0", 32'(seg), 32'hC0);
    check("t6_cnt", 32'(count_bcd), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_counter_display.md
Name: seg_counter_display

Overview:
- Parametrised multiplexed seven-segment counter/display for N digits.
- Holds a BCD counter that advances on a prescaled tick, counting up or down, with pause, load, wrap flag, leading-zero blanking and per-digit decimal points.
- Drives common-anode LED digits directly: active-low digit selects and active-low segments.
- Counts natively in BCD, so no binary-to-BCD converter is needed.

Parameters:
- DIGITS, 6, number of display digits and counter BCD digits (1..8).
- TICK_MAX, 499_999, prescaler terminal value; tick period is TICK_MAX+1 clocks (10 ms at 50 MHz).
- SCAN_MAX, 49_999, scan terminal value; each digit is held for SCAN_MAX+1 clocks.
- BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
- sys_clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, count enable; 0 freezes the prescaler and the count.
- up_dn, in, 1, 1 = count up, 0 = count down.
- load, in, 1, synchronous load strobe.
- load_val, in, 4*DIGITS, BCD load value; digit 0 is bits [3:0].
- dp_mask, in, DIGITS, decimal-point enable per digit; bit i lights the dp on digit i.
- count_bcd, out, 4*DIGITS, current counter value in BCD.
- wrap, out, 1, one-cycle pulse on counter wrap.
- sel, out, DIGITS, digit select, active low, one-hot; sel[0] is the rightmost digit.
- seg, out, 8, segments, active low; seg[7] = dp, seg[6:0] = g,f,e,d,c,b,a.

Behaviour:
- Reset (async, rst_n=0):
  - prescaler = 0, count_bcd = 0, wrap = 0.
  - scan counter = 0, digit index = 0.
  - sel = all ones, seg = 8'hFF.
- Prescaler:
  - Increments only while en=1; holds while en=0.
  - At TICK_MAX it returns to 0 and generates an internal tick in that cycle.
- Count update: at the clock edge where tick=1 and en=1:
  - up_dn=1: digit-wise BCD increment with carry ripple. 10^DIGITS-1 goes to 0 with wrap=1.
  - up_dn=0: BCD decrement with borrow. 0 goes to 10^DIGITS-1 (all nines) with wrap=1.
  - wrap is registered and high for exactly the cycle after that edge.
- Load has priority over tick:
  - On an edge with load=1, count_bcd <= load_val, prescaler <= 0, wrap <= 0.
  - Load works regardless of en.
  - Any load digit >9 is clamped to 9.
- up_dn is sampled only at tick edges; a change mid-period has no other effect.
- Scan:
  - The scan counter free-runs, independent of en.
  - At SCAN_MAX it returns to 0 and the digit index advances; index DIGITS-1 wraps to 0.
- Outputs:
  - sel and seg are registered every cycle from (digit index, count_bcd, dp_mask).
  - Latency is 1 clock from an index or count change to the pins.
  - sel = ~(1<<index); exactly one bit is low at all times after the first post-reset clock.
- Segment decode (active low, {g..a}):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19.
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Any other code gives 7'h7F (blank).
- seg[7] = ~dp_mask[index].
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i is blanked (seg[6:0]=7'h7F) if it and all digits above it are 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - The dp is still driven per dp_mask on blanked digits.
- Reset mid-count or mid-scan returns every register to its reset value immediately; there is no partial state.

Test Plan (DIGITS=4, TICK_MAX=3, SCAN_MAX=1 unless noted):
1. Reset release, en=1, up_dn=1, 40 clocks:
   - count_bcd is 0x0000 → 0x0001 after 4 clocks, then +1 every 4 clocks; it reaches 0x0009 then 0x0010 (BCD carry).
   - wrap stays 0.
2. Load 0x9998, en=1, up_dn=1:
   - Next ticks give 0x9999, then 0x0000 with wrap high for exactly 1 clock.
3. Load 0x0001, up_dn=0:
   - Ticks give 0x0000, then 0x9999 with a wrap pulse, then 0x9998.
4. Load and tick coincident with load_val=0x12F4:
   - count_bcd = 0x1294 (clamped digit); prescaler restarts and the next change comes 4 clocks later.
   - en=0 for 20 clocks leaves count_bcd constant.
5. Scan, count 0x0205, dp_mask=4'b0010, BLANK_LZ=1:
   - sel cycles 1110, 1101, 1011, 0111, each held 2 clocks.
   - seg sequence: 8'h92, 8'h40 (dp on), 8'hA4, 8'hFF.
   - Count 0x0000 shows 8'hC0 on digit 0 and 8'hFF on digits 1–3.
6. Assert rst_n=0 mid-scan with count 0x0777:
   - sel=4'hF, seg=8'hFF, count_bcd=0, wrap=0 asynchronously.
   - After release, digit 0 is selected after 1 clock.
